// File: rtl/sram8t_array.sv
// Two-port 8T SRAM array model: one masked write port, one registered read port,
// selectable read-during-write result and a hardware clear sequencer.
//
// state | meaning
// ------+-----------------------------------------------------------
// CLEAR | sequencer zeroes one row per edge; ports ignored, busy = 1
// READY | normal write/read operation; init_req restarts the clear
module sram8t_array #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int RDW_MODE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_req,
    output logic              busy,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] wmask,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            state;
    state_t            stateNext;
    logic [ADDR_W-1:0] clrPtr;
    logic [ADDR_W-1:0] clrPtrNext;
    logic              wrAccept;
    logic              rdAccept;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] oldWrWord;
    logic [DATA_W-1:0] mergedWord;
    logic [DATA_W-1:0] rdWord;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= CLEAR;
            clrPtr <= '0;
        end else begin
            state  <= stateNext;
            clrPtr <= clrPtrNext;
        end
    end

    // An init_req edge in READY swallows any port activity of the same cycle.
    always_comb begin
        stateNext  = state;
        clrPtrNext = clrPtr;
        wrAccept   = 1'b0;
        rdAccept   = 1'b0;
        case (state)
            CLEAR: begin
                clrPtrNext = clrPtr + ADDR_W'(1);
                if (clrPtr == LAST_ROW) begin
                    stateNext = READY;
                end
            end
            READY: begin
                if (init_req) begin
                    stateNext  = CLEAR;
                    clrPtrNext = '0;
                end else begin
                    wrAccept = we;
                    rdAccept = re;
                end
            end
            default: begin
                stateNext  = CLEAR;
                clrPtrNext = '0;
            end
        endcase
    end

    assign busy = (state == CLEAR);

    assign oldWrWord  = mem[waddr];
    assign mergedWord = (oldWrWord & ~wmask) | (wdata & wmask);

    // Array has no reset of its own; the sequencer is the only way it gets zeroed.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clrPtr] <= '0;
        end else if (wrAccept) begin
            mem[waddr] <= mergedWord;
        end
    end

    always_comb begin
        rdWord = mem[raddr];
        if ((RDW_MODE != 0) && wrAccept && (waddr == raddr)) begin
            rdWord = mergedWord;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rdAccept;
            if (rdAccept) begin
                rdata <= rdWord;
            end
        end
    end

endmodule

// File: tb/tb_sram8t_array.sv
// Directed bench for sram8t_array: two instances (old-data and new-data RDW modes)
// share the same stimulus; each task checks its own scenario inline.
module tb_sram8t_array;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       init_req = 1'b0;
    logic       we = 1'b0;
    logic [3:0] waddr = '0;
    logic [7:0] wdata = '0;
    logic [7:0] wmask = '0;
    logic       re = 1'b0;
    logic [3:0] raddr = '0;

    logic       busy0, busy1;
    logic [7:0] rdata0, rdata1;
    logic       rvalid0, rvalid1;

    int checks = 0;
    int errors = 0;

    sram8t_array #(.DATA_W(8), .ADDR_W(4), .RDW_MODE(0)) dutOld (
        .clk(clk), .rst_n(rst_n), .init_req(init_req), .busy(busy0),
        .we(we), .waddr(waddr), .wdata(wdata), .wmask(wmask),
        .re(re), .raddr(raddr), .rdata(rdata0), .rvalid(rvalid0)
    );

    sram8t_array #(.DATA_W(8), .ADDR_W(4), .RDW_MODE(1)) dutNew (
        .clk(clk), .rst_n(rst_n), .init_req(init_req), .busy(busy1),
        .we(we), .waddr(waddr), .wdata(wdata), .wmask(wmask),
        .re(re), .raddr(raddr), .rdata(rdata1), .rvalid(rvalid1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; re = 1'b0; init_req = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (busy0 !== 1'b1 || rvalid0 !== 1'b0 || rdata0 !== 8'h00) begin
            errors++;
            $display("FAIL reset_values: busy=%b rvalid=%b rdata=%h, want 1 0 00", busy0, rvalid0, rdata0);
        end
        tick(); tick();
        rst_n = 1'b1;
        begin
            int n = 0;
            while (busy0 && n < 100) begin tick(); n++; end
            checks++;
            if (n !== 16) begin
                errors++;
                $display("FAIL reset_busy_len: got %0d cycles, want 16", n);
            end
        end
        for (int i = 0; i < 16; i++) begin
            raddr = 4'(i); re = 1'b1;
            tick();
            checks++;
            if (rvalid0 !== 1'b1 || rdata0 !== 8'h00 || rdata1 !== 8'h00) begin
                errors++;
                $display("FAIL reset_read_zero[%0d]: rvalid=%b rdata=%h/%h, want 1 00/00", i, rvalid0, rdata0, rdata1);
            end
        end
        idle();
        tick();
        checks++;
        if (rvalid0 !== 1'b0 || rdata0 !== 8'h00) begin
            errors++;
            $display("FAIL reset_rvalid_drop: rvalid=%b rdata=%h, want 0 00", rvalid0, rdata0);
        end
    endtask

    task automatic test_mask();
        we = 1'b1; waddr = 4'd3; wdata = 8'hA5; wmask = 8'hFF;
        tick();
        wdata = 8'h0F; wmask = 8'h0C;
        tick();
        idle();
        raddr = 4'd3; re = 1'b1;
        tick();
        idle();
        checks++;
        if (rvalid0 !== 1'b1 || rdata0 !== 8'hAD) begin
            errors++;
            $display("FAIL mask_merge: rvalid=%b rdata=%h, want 1 AD", rvalid0, rdata0);
        end
        we = 1'b1; waddr = 4'd3; wdata = 8'hFF; wmask = 8'h00;
        tick();
        we = 1'b0; re = 1'b1; raddr = 4'd3;
        tick();
        idle();
        checks++;
        if (rdata0 !== 8'hAD) begin
            errors++;
            $display("FAIL mask_zero: rdata=%h, want AD", rdata0);
        end
    endtask

    task automatic test_rdw();
        we = 1'b1; wmask = 8'hFF; waddr = 4'd7; wdata = 8'h11;
        tick();
        waddr = 4'd8; wdata = 8'h44;
        tick();
        waddr = 4'd7; wdata = 8'h22; re = 1'b1; raddr = 4'd7;
        tick();
        idle();
        checks++;
        if (rdata0 !== 8'h11 || rdata1 !== 8'h22 || rvalid0 !== 1'b1 || rvalid1 !== 1'b1) begin
            errors++;
            $display("FAIL rdw_same_addr: rdata old/new=%h/%h rvalid=%b%b, want 11/22 11", rdata0, rdata1, rvalid0, rvalid1);
        end
        re = 1'b1; raddr = 4'd7;
        tick();
        checks++;
        if (rdata0 !== 8'h22 || rdata1 !== 8'h22) begin
            errors++;
            $display("FAIL rdw_after_write: rdata=%h/%h, want 22/22", rdata0, rdata1);
        end
        we = 1'b1; waddr = 4'd7; wdata = 8'h33; wmask = 8'hF0; raddr = 4'd7;
        tick();
        checks++;
        if (rdata0 !== 8'h22 || rdata1 !== 8'h32) begin
            errors++;
            $display("FAIL rdw_masked: rdata=%h/%h, want 22/32", rdata0, rdata1);
        end
        wmask = 8'hFF; wdata = 8'h55; raddr = 4'd8;
        tick();
        idle();
        checks++;
        if (rdata0 !== 8'h44 || rdata1 !== 8'h44) begin
            errors++;
            $display("FAIL rdw_diff_addr: rdata=%h/%h, want 44/44", rdata0, rdata1);
        end
    endtask

    task automatic test_init();
        for (int i = 0; i < 16; i++) begin
            we = 1'b1; waddr = 4'(i); wdata = 8'(i); wmask = 8'hFF;
            tick();
        end
        we = 1'b0; re = 1'b1; raddr = 4'd9;
        tick();
        checks++;
        if (rdata0 !== 8'h09) begin
            errors++;
            $display("FAIL init_prefill: rdata=%h, want 09", rdata0);
        end
        init_req = 1'b1; we = 1'b1; waddr = 4'd0; wdata = 8'hFF; re = 1'b1; raddr = 4'd5;
        tick();
        idle();
        checks++;
        if (busy0 !== 1'b1 || rvalid0 !== 1'b0 || rdata0 !== 8'h09) begin
            errors++;
            $display("FAIL init_start: busy=%b rvalid=%b rdata=%h, want 1 0 09", busy0, rvalid0, rdata0);
        end
        begin
            int n = 0;
            while (busy0 && n < 100) begin tick(); n++; end
            checks++;
            if (n !== 16) begin
                errors++;
                $display("FAIL init_busy_len: got %0d cycles, want 16", n);
            end
        end
        begin
            int bad = 0;
            for (int i = 0; i < 16; i++) begin
                re = 1'b1; raddr = 4'(i);
                tick();
                if (rvalid0 !== 1'b1 || rdata0 !== 8'h00) bad++;
            end
            idle();
            checks++;
            if (bad !== 0) begin
                errors++;
                $display("FAIL init_read_zero: %0d bad reads, want 0", bad);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        we = 1'b1; waddr = 4'd2; wdata = 8'h5A; wmask = 8'hFF;
        tick();
        we = 1'b0; re = 1'b1; raddr = 4'd2;
        tick();
        idle();
        init_req = 1'b1;
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            re = 1'b1; raddr = 4'd2;
            tick();
        end
        re = 1'b0;
        checks++;
        if (busy0 !== 1'b1 || rvalid0 !== 1'b0 || rdata0 !== 8'h5A) begin
            errors++;
            $display("FAIL clear_ignores_re: busy=%b rvalid=%b rdata=%h, want 1 0 5A", busy0, rvalid0, rdata0);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy0 !== 1'b1 || rvalid0 !== 1'b0 || rdata0 !== 8'h00) begin
            errors++;
            $display("FAIL midclear_reset: busy=%b rvalid=%b rdata=%h, want 1 0 00", busy0, rvalid0, rdata0);
        end
        tick(); tick();
        rst_n = 1'b1;
        begin
            int n = 0;
            int vbad = 0;
            while (busy0 && n < 100) begin
                re = 1'b1; raddr = 4'(n);
                tick();
                n++;
                if (rvalid0 !== 1'b0) vbad++;
            end
            idle();
            checks++;
            if (n !== 16) begin
                errors++;
                $display("FAIL midclear_busy_len: got %0d cycles, want 16", n);
            end
            checks++;
            if (vbad !== 0) begin
                errors++;
                $display("FAIL midclear_rvalid: %0d cycles with rvalid high, want 0", vbad);
            end
        end
        re = 1'b1; raddr = 4'd2;
        tick();
        idle();
        checks++;
        if (rvalid0 !== 1'b1 || rdata0 !== 8'h00) begin
            errors++;
            $display("FAIL midclear_cleared: rvalid=%b rdata=%h, want 1 00", rvalid0, rdata0);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            we = 1'b1; waddr = 4'(i); wdata = 8'((i * 3 + 1) ^ 8'h60); wmask = 8'hFF;
            tick();
        end
        we = 1'b0;
        begin
            int bad = 0;
            int vcount = 0;
            for (int i = 0; i < 16; i++) begin
                re = 1'b1; raddr = 4'(i);
                tick();
                if (rvalid0 === 1'b1) vcount++;
                if (rdata0 !== 8'((i * 3 + 1) ^ 8'h60) || rdata1 !== 8'((i * 3 + 1) ^ 8'h60)) bad++;
            end
            idle();
            checks++;
            if (vcount !== 16) begin
                errors++;
                $display("FAIL b2b_rvalid: high %0d cycles, want 16", vcount);
            end
            checks++;
            if (bad !== 0) begin
                errors++;
                $display("FAIL b2b_data: %0d wrong words, want 0", bad);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mask();
        test_rdw();
        test_init();
        test_reset_mid_clear();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram8t_array.md
Name: sram8t_array

Overview:
- Parametrised behavioural model of a two-port SRAM array built from 8T cells: one write port and one decoupled read port, usable in the same cycle.
- Adds a synchronous clock, a per-bit write mask, a selectable read-during-write mode, and a hardware clear sequencer.
- Sits above the single-cell model as the storage macro used by register files and buffers.

Parameters:
- DATA_W, 8, word width in bits (1..64).
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words.
- RDW_MODE, 0, same-address read-during-write result: 0 = old data, 1 = new (merged) data.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- init_req  input  1  request a full array clear; sampled only when not busy.
- busy  output  1  high while the clear sequencer runs; ports are ignored while high.
- we  input  1  write enable.
- waddr  input  ADDR_W  write address.
- wdata  input  DATA_W  write data.
- wmask  input  DATA_W  per-bit write mask; 1 = bit is written.
- re  input  1  read enable.
- raddr  input  ADDR_W  read address.
- rdata  output  DATA_W  registered read data.
- rvalid  output  1  high for one cycle when rdata carries data from a read accepted on the previous edge.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = CLEAR, clr_ptr = 0, busy = 1, rdata = 0, rvalid = 0.
  - Array contents are not reset directly; they are zeroed by the sequencer.
- State machine has two states, CLEAR and READY.
  - CLEAR: each edge writes mem[clr_ptr] = 0 and increments clr_ptr. On the edge that clears row DEPTH-1, go to READY and drop busy. busy is therefore high for exactly DEPTH cycles after rst_n rises.
  - READY, init_req = 1 at an edge: go to CLEAR, clr_ptr = 0, busy = 1 from the next cycle. Any we/re in that same cycle is dropped: no write, rvalid = 0 next cycle.
  - READY, init_req = 0: normal port operation.
- While busy = 1: we, re and init_req are ignored. rvalid = 0 and rdata holds its value.
- Write, accepted when we = 1 in READY:
  - mem[waddr] = (mem[waddr] & ~wmask) | (wdata & wmask).
  - wmask = 0 leaves the word unchanged and is legal.
- Read, accepted when re = 1 in READY:
  - rdata = mem[raddr] on the same edge; rvalid = 1 for the following cycle.
  - Latency is 1 cycle, and back-to-back reads are supported every cycle.
  - When re = 0, rvalid = 0 and rdata holds its last value.
- Same-cycle write and read:
  - Different addresses: fully independent.
  - Same address, RDW_MODE = 0: rdata is the pre-write word.
  - Same address, RDW_MODE = 1: rdata is the merged post-write word, masked bits included.
- Addresses wrap naturally; with DEPTH = 2**ADDR_W there are no out-of-range addresses.
- Reset asserted mid-CLEAR or mid-operation: returns immediately to reset values, and a full DEPTH-cycle clear restarts after release.
- No X may appear on rdata after the first clear completes.

Test Plan:
- Reset release, ADDR_W = 4 -> busy high for exactly 16 cycles; then reading every address returns 0x00, each with rvalid = 1 one cycle after re.
- Write 0xA5 with wmask 0xFF to addr 3, then write 0x0F with wmask 0x0C to addr 3 -> read addr 3 returns 0xA5 & ~0x0C | 0x0C = 0xAD.
- Same-cycle we/re to addr 7 (old 0x11, new 0x22, mask 0xFF) -> rdata = 0x11 with RDW_MODE = 0 and 0x22 with RDW_MODE = 1. Same-cycle access to addrs 7 and 8 reads addr 8 unaffected.
- Fill all 16 addresses with value = address, then pulse init_req together with we to addr 0 -> write dropped, busy high for 16 cycles, all reads then return 0.
- Drop rst_n at cycle 5 of a clear, release 2 cycles later -> busy stays high 16 further cycles, rvalid stays 0 throughout, and re pulses during busy produce no rvalid.
- Back-to-back reads of addrs 0..15 on consecutive cycles after writes -> rvalid continuously high for 16 cycles, with the correct data each cycle.
